// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared op and state encodings for the multiply/divide unit
package muldiv_unit_pkg;
   typedef enum logic [1:0] {OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3} op_e;
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2} state_e;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU with HI/LO registers
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   state_e             state, state_n;
   op_e                op_r;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mag_b, a_raw;
   logic               neg_res, neg_rem;
   logic               signed_in, div_r;
   logic [WIDTH-1:0]   mag_a_in, mag_b_in, q_fix, r_fix;
   logic [WIDTH:0]     msum, dsh, ddiff;
   logic [2*WIDTH-1:0] prod_fix;

   assign busy = (state != IDLE);

   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;

   // next state: IDLE -> CALC on start, CALC runs WIDTH iterations, FINISH lasts one cycle
   always_comb begin
      state_n = state;
      state_n = (state == IDLE) ? (start ? CALC : IDLE) :
                (state == CALC) ? ((cnt == CW'(WIDTH - 1)) ? FINISH : CALC) : IDLE;
   end

   // operand magnitudes, one shift-add / restoring-subtract step, and sign correction
   always_comb begin
      signed_in = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
      div_r     = (op_r == OP_DIV) || (op_r == OP_DIVU);
      mag_a_in  = (signed_in && operand_a[WIDTH-1]) ? -operand_a : operand_a;
      mag_b_in  = (signed_in && operand_b[WIDTH-1]) ? -operand_b : operand_b;
      msum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
      dsh       = acc[2*WIDTH-1:WIDTH-1];
      ddiff     = dsh - {1'b0, mag_b};
      q_fix     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      r_fix     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      prod_fix  = neg_res ? -acc : acc;
   end

   // datapath: operand capture, iteration, HI/LO writes and the done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r    <= OP_MULT;
         cnt     <= '0;
         acc     <= '0;
         mag_b   <= '0;
         a_raw   <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         done <= (state == FINISH);
         if (state == IDLE) begin
            if (hi_we) hi <= operand_a;
            if (lo_we) lo <= operand_a;
            if (start) begin
               op_r    <= op_e'(op);
               cnt     <= '0;
               acc     <= {{WIDTH{1'b0}}, mag_a_in};
               mag_b   <= mag_b_in;
               a_raw   <= operand_a;
               neg_res <= signed_in && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
               neg_rem <= signed_in && operand_a[WIDTH-1];
            end
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            acc <= div_r ? (ddiff[WIDTH] ? {dsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                         : {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                         : {msum, acc[WIDTH-1:1]};
         end else if (div_r) begin
            lo <= (mag_b == '0) ? '1 : q_fix;
            hi <= (mag_b == '0) ? a_raw : r_fix;
         end else begin
            {hi, lo} <= prod_fix;
         end
      end
   end
endmodule
